// File: rtl/hum_digit_sequencer.sv
// Humidity digit sequencer: takes a binary humidity percentage over valid/ready,
// splits it into tens/ones digit codes by repeated subtraction, and commits the
// digits to the display only on frame_start so a frame never tears. Blanks the
// display to dashes after STALE_FRAMES frames with no fresh commit.
module hum_digit_sequencer #(
    parameter int         STALE_FRAMES = 600,
    parameter logic [3:0] DASH_CODE    = 4'd10,
    parameter int         MAX_VALUE    = 99
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] hum_raw,
    input  logic       hum_valid,
    output logic       hum_ready,
    input  logic       frame_start,
    output logic [3:0] hum_value_10,
    output logic [3:0] hum_value_1,
    output logic       stale,
    output logic       busy
);

    localparam int            CW        = $clog2(STALE_FRAMES + 1);
    localparam logic [CW-1:0] STALE_MAX = CW'(STALE_FRAMES);
    localparam logic [7:0]    MAX_V     = 8'(MAX_VALUE);

    typedef enum logic [1:0] {IDLE, CONVERT, PENDING} state_t;

    state_t        state, state_nxt;
    logic [6:0]    rem, rem_nxt;
    logic [3:0]    tens_acc, tens_nxt;
    logic [3:0]    ones_acc, ones_nxt;
    logic [CW-1:0] frame_cnt, frame_cnt_nxt;
    logic [3:0]    d10_nxt, d1_nxt;
    logic          stale_nxt;
    logic          commit;

    // State and all registered outputs; hum_ready/busy follow the next state so
    // they are valid in the same cycle the FSM enters that state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            rem          <= '0;
            tens_acc     <= '0;
            ones_acc     <= '0;
            frame_cnt    <= '0;
            hum_value_10 <= DASH_CODE;
            hum_value_1  <= DASH_CODE;
            stale        <= 1'b1;
            hum_ready    <= 1'b1;
            busy         <= 1'b0;
        end else begin
            state        <= state_nxt;
            rem          <= rem_nxt;
            tens_acc     <= tens_nxt;
            ones_acc     <= ones_nxt;
            frame_cnt    <= frame_cnt_nxt;
            hum_value_10 <= d10_nxt;
            hum_value_1  <= d1_nxt;
            stale        <= stale_nxt;
            hum_ready    <= (state_nxt == IDLE);
            busy         <= (state_nxt != IDLE);
        end
    end

    // Next state: accept, subtract tens one per cycle, then wait for a frame.
    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        tens_nxt  = tens_acc;
        ones_nxt  = ones_acc;
        case (state)
            IDLE: begin
                if (hum_valid && hum_ready) begin
                    rem_nxt   = (hum_raw > MAX_V) ? MAX_V[6:0] : hum_raw[6:0];
                    tens_nxt  = '0;
                    state_nxt = CONVERT;
                end
            end
            CONVERT: begin
                if (rem >= 7'd10) begin
                    rem_nxt  = rem - 7'd10;
                    tens_nxt = tens_acc + 4'd1;
                end else begin
                    ones_nxt  = rem[3:0];
                    state_nxt = PENDING;
                end
            end
            PENDING: begin
                if (frame_start) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Display outputs: commit on a frame in PENDING, otherwise age the stale
    // timer and blank to dashes on the frame that reaches the limit.
    always_comb begin
        commit        = (state == PENDING) && frame_start;
        d10_nxt       = hum_value_10;
        d1_nxt        = hum_value_1;
        stale_nxt     = stale;
        frame_cnt_nxt = frame_cnt;
        if (commit) begin
            d10_nxt       = tens_acc;
            d1_nxt        = ones_acc;
            stale_nxt     = 1'b0;
            frame_cnt_nxt = '0;
        end else if (frame_start && frame_cnt != STALE_MAX) begin
            frame_cnt_nxt = frame_cnt + CW'(1);
            if (frame_cnt_nxt == STALE_MAX) begin
                stale_nxt = 1'b1;
                d10_nxt   = DASH_CODE;
                d1_nxt    = DASH_CODE;
            end
        end
    end

endmodule

// File: tb/tb_hum_digit_sequencer.sv
// Bench for hum_digit_sequencer: directed scenarios plus randomized samples whose
// expected digits and conversion length come from decimal arithmetic.
module tb_hum_digit_sequencer;

    localparam int STALE = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] hum_raw = '0;
    logic       hum_valid = 1'b0;
    logic       hum_ready;
    logic       frame_start = 1'b0;
    logic [3:0] hum_value_10, hum_value_1;
    logic       stale, busy;

    int n_cmp = 0;
    int n_err = 0;
    logic [3:0] m10 = 4'd10;   // digits the display should be showing
    logic [3:0] m1  = 4'd10;

    hum_digit_sequencer #(.STALE_FRAMES(STALE), .DASH_CODE(4'd10), .MAX_VALUE(99)) dut (
        .clk(clk), .reset(reset), .hum_raw(hum_raw), .hum_valid(hum_valid),
        .hum_ready(hum_ready), .frame_start(frame_start),
        .hum_value_10(hum_value_10), .hum_value_1(hum_value_1),
        .stale(stale), .busy(busy)
    );

    always #5 clk = ~clk;

    // {tens, ones, stale, ready, busy}
    function automatic logic [10:0] snap();
        return {hum_value_10, hum_value_1, stale, hum_ready, busy};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int v);
        hum_raw = 8'(v);
        hum_valid = 1'b1;
        tick();
        hum_valid = 1'b0;
    endtask

    task automatic frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        n_cmp++;
        if (snap() !== {4'd10, 4'd10, 1'b1, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL reset_state: got %h expected %h", snap(), {4'd10, 4'd10, 3'b110});
        end
        tick();
        n_cmp++;
        if (snap() !== {4'd10, 4'd10, 1'b1, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL reset_idle_hold: got %h expected %h", snap(), {4'd10, 4'd10, 3'b110});
        end
        m10 = 4'd10; m1 = 4'd10;
    endtask

    task automatic test_basic();
        int bad = 0;
        send(47);
        for (int i = 0; i < 20; i++) begin
            if (hum_ready !== 1'b0 || busy !== 1'b1 || hum_value_10 !== 4'd10 || hum_value_1 !== 4'd10) bad++;
            tick();
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL basic_wait: %0d bad cycles, expected 0 (ready=0 busy=1 digits held)", bad);
        end
        frame();
        n_cmp++;
        if (snap() !== {4'd4, 4'd7, 1'b0, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL basic_commit: got %h expected %h", snap(), {4'd4, 4'd7, 3'b010});
        end
        m10 = 4'd4; m1 = 4'd7;
    endtask

    // A frame on the last conversion cycle must not commit; the next one must.
    task automatic test_convert_len();
        int vals[$];
        vals = '{0, 99, 200, 9, 10, 100, 255};
        for (int i = 0; i < 16; i++) vals.push_back(int'($urandom_range(0, 255)));
        foreach (vals[k]) begin
            int c, t, o;
            c = (vals[k] > 99) ? 99 : vals[k];
            t = c / 10;
            o = c % 10;
            send(vals[k]);
            repeat (t) tick();
            frame();
            n_cmp++;
            if (snap() !== {m10, m1, 1'b0, 1'b0, 1'b1}) begin
                n_err++;
                $display("FAIL conv_edge_frame v=%0d: got %h expected %h", vals[k], snap(), {m10, m1, 3'b001});
            end
            frame();
            n_cmp++;
            if (snap() !== {4'(t), 4'(o), 1'b0, 1'b1, 1'b0}) begin
                n_err++;
                $display("FAIL conv_commit v=%0d: got %h expected %h", vals[k], snap(), {4'(t), 4'(o), 3'b010});
            end
            m10 = 4'(t); m1 = 4'(o);
        end
    endtask

    task automatic test_back_to_back();
        send(63);
        hum_raw = 8'd12;
        hum_valid = 1'b1;
        repeat (10) tick();
        n_cmp++;
        if (hum_ready !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_blocked: got ready=%b busy=%b expected ready=0 busy=1", hum_ready, busy);
        end
        frame();
        n_cmp++;
        if (snap() !== {4'd6, 4'd3, 1'b0, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL b2b_first: got %h expected %h", snap(), {4'd6, 4'd3, 3'b010});
        end
        tick();
        hum_valid = 1'b0;
        n_cmp++;
        if (hum_ready !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_accept: got ready=%b busy=%b expected ready=0 busy=1", hum_ready, busy);
        end
        repeat (4) tick();
        frame();
        n_cmp++;
        if (snap() !== {4'd1, 4'd2, 1'b0, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL b2b_second: got %h expected %h", snap(), {4'd1, 4'd2, 3'b010});
        end
        m10 = 4'd1; m1 = 4'd2;
    endtask

    task automatic test_stale();
        send(55);
        repeat (8) tick();
        frame();
        m10 = 4'd5; m1 = 4'd5;
        for (int k = 1; k <= STALE + 1; k++) begin
            logic [10:0] exp;
            frame();
            repeat (2) tick();
            exp = (k >= STALE) ? {4'd10, 4'd10, 1'b1, 1'b1, 1'b0} : {4'd5, 4'd5, 1'b0, 1'b1, 1'b0};
            n_cmp++;
            if (snap() !== exp) begin
                n_err++;
                $display("FAIL stale_frame%0d: got %h expected %h", k, snap(), exp);
            end
        end
        send(30);
        repeat (5) tick();
        frame();
        n_cmp++;
        if (snap() !== {4'd3, 4'd0, 1'b0, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL stale_recover: got %h expected %h", snap(), {4'd3, 4'd0, 3'b010});
        end
        m10 = 4'd3; m1 = 4'd0;
    endtask

    task automatic test_reset_abort();
        for (int p = 0; p < 2; p++) begin
            send(81);
            repeat (p == 0 ? 1 : 12) tick();
            reset = 1'b1;
            tick();
            reset = 1'b0;
            n_cmp++;
            if (snap() !== {4'd10, 4'd10, 1'b1, 1'b1, 1'b0}) begin
                n_err++;
                $display("FAIL abort%0d_reset: got %h expected %h", p, snap(), {4'd10, 4'd10, 3'b110});
            end
            frame();
            tick();
            n_cmp++;
            if (snap() !== {4'd10, 4'd10, 1'b1, 1'b1, 1'b0}) begin
                n_err++;
                $display("FAIL abort%0d_frame: got %h expected %h", p, snap(), {4'd10, 4'd10, 3'b110});
            end
        end
        m10 = 4'd10; m1 = 4'd10;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_convert_len();
        test_back_to_back();
        test_stale();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hum_digit_sequencer.md
Name: hum_digit_sequencer

Overview:
Sits between the humidity sensor reader and the two-digit humidity display. Accepts a binary humidity percentage with a valid/ready handshake and converts it to tens/ones digit codes by sequential repeated subtraction. Commits new digits to the display only on a frame-start pulse, so the display never tears mid-frame. Blanks the display to dashes when the sensor goes stale.

Parameters:
STALE_FRAMES, 600, frame_start pulses without a committed sample before the display shows dashes (10 s at 60 Hz)
DASH_CODE, 10, 4-bit character code the font renders as '-'
MAX_VALUE, 99, clamp ceiling for the incoming value; must be <= 99

Ports:
clk  input  1  system clock (pixel clock domain)
reset  input  1  synchronous, active-high reset
hum_raw  input  8  unsigned humidity percentage from the sensor reader
hum_valid  input  1  hum_raw is valid this cycle
hum_ready  output  1  block accepts a sample this cycle
frame_start  input  1  single-cycle pulse at the start of vertical blank
hum_value_10  output  4  tens digit code to the display
hum_value_1  output  4  ones digit code to the display
stale  output  1  display is showing dashes because no fresh data has arrived
busy  output  1  conversion or commit is pending

Behaviour:
- One clock, synchronous active-high reset. All outputs are registered.
- Reset values:
  - hum_value_10 = hum_value_1 = DASH_CODE
  - stale = 1, hum_ready = 1, busy = 0
  - frame counter = 0, state = IDLE
- FSM states: IDLE, CONVERT, PENDING.
- IDLE:
  - hum_ready = 1, busy = 0.
  - A transfer occurs when hum_valid && hum_ready.
  - On a transfer, latch rem = min(hum_raw, MAX_VALUE), clear tens_acc, go to CONVERT.
- CONVERT:
  - hum_ready = 0, busy = 1.
  - Each cycle with rem >= 10: rem -= 10, tens_acc += 1.
  - Otherwise: ones_acc = rem[3:0] and go to PENDING.
  - Cycles spent in CONVERT = tens + 1, with a maximum of 10.
- PENDING:
  - hum_ready = 0, busy = 1. hum_valid is ignored.
  - On frame_start: hum_value_10 <= tens_acc, hum_value_1 <= ones_acc, stale <= 0, frame counter <= 0, go to IDLE.
  - New digits are visible the cycle after that frame_start.
- A frame_start that coincides with the last CONVERT cycle does not commit; the commit waits for the next frame_start.
- Stale timer:
  - On every frame_start not consumed by a PENDING commit, the frame counter increments, saturating at STALE_FRAMES.
  - When the increment reaches STALE_FRAMES: stale <= 1 and both digit outputs <= DASH_CODE, in the same cycle.
  - While stale, later commits restore the digits normally.
  - Counter width is clog2(STALE_FRAMES+1).
- The stale timer keeps running in IDLE and CONVERT. It is not reset by a transfer, only by a commit.
- Values above MAX_VALUE, including 100..255, display as "99".
- Leading zero is shown: a raw value of 5 displays as "05".
- Reset asserted in any state aborts the conversion, discards pending digits and restores the reset values on the next edge.
- No combinational path from hum_valid to hum_ready.

Test Plan:
- Reset, hold 3 cycles -> hum_value_10 = hum_value_1 = 10, stale = 1, hum_ready = 1, busy = 0.
- hum_raw = 47 with one-cycle hum_valid, frame_start 20 cycles later -> hum_ready low for 5 CONVERT cycles plus the PENDING wait; outputs change to 4/7 the cycle after frame_start; stale = 0; hum_ready high again.
- hum_raw = 0, then 99, then 200 (each committed) -> 0/0, 9/9, 9/9. CONVERT lasts 1, 10 and 10 cycles respectively.
- Send 63, hold hum_valid with 12 during PENDING, then frame_start -> 12 is not accepted while hum_ready = 0; display shows 6/3; 12 is accepted on the first IDLE cycle and shows 1/2 at the following frame_start.
- STALE_FRAMES = 4: commit 55, then 4 frame_start pulses with no sample -> after the 4th pulse, outputs = 10/10 and stale = 1. Send 30 and pulse frame_start -> 3/0, stale = 0.
- Assert reset while in CONVERT for 81 and again while in PENDING -> the pending value is never displayed; outputs return to 10/10, stale = 1, hum_ready = 1.
